// File: rtl/iop_pkg.sv
// Shared constants, state encoding and status-word helpers for the IOP device controllers.
package iop_pkg;

    localparam int unsigned ADDR_W = 17;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BA_W   = 19;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned BYTE_W = 8;

    localparam logic [2:0] FNC_SIO = 3'd0;
    localparam logic [2:0] FNC_TIO = 3'd1;

    localparam logic [7:0] CMD_ORDER_WRITE = 8'h01;
    localparam logic [7:0] CMD_ORDER_READ  = 8'h02;

    localparam logic [15:0]       STATUS_NORMAL_HI = 16'h0100;
    localparam logic [DATA_W-1:0] STATUS_BAD_ORDER = 32'hFF00_0000;
    localparam logic [DATA_W-1:0] STATUS_TIO       = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        PTR,
        CMD0,
        CMD1,
        FETCH,
        EMIT,
        STATUS,
        HOLD
    } iop_state_e;

    typedef enum logic [1:0] {
        STAT_NORMAL,
        STAT_BAD,
        STAT_TIO
    } stat_kind_e;

    function automatic logic [DATA_W-1:0] status_normal(input logic [CNT_W-1:0] sent);
        return {STATUS_NORMAL_HI, sent};
    endfunction

endpackage

// File: rtl/iop_byte_select.sv
// Picks one byte lane out of a word; lane 0 is the most significant byte.
module iop_byte_select
    import iop_pkg::*;
(
    input  logic [DATA_W-1:0] i_word,
    input  logic [1:0]        i_lane,
    output logic [BYTE_W-1:0] o_byte
);

    always_comb begin
        o_byte = i_word[31:24];
        unique case (i_lane)
            2'd0: o_byte = i_word[31:24];
            2'd1: o_byte = i_word[23:16];
            2'd2: o_byte = i_word[15:8];
            2'd3: o_byte = i_word[7:0];
            default: o_byte = i_word[31:24];
        endcase
    end

endmodule

// File: rtl/papertape_punch_iop.sv
// Paper-tape punch controller: walks a WRITE command doubleword, streams bytes
// to the punch with a valid/ready handshake and posts a completion status word.
module papertape_punch_iop
    import iop_pkg::*;
#(
    parameter logic [7:0]        DEVICE_ADDR  = 8'h05,
    parameter logic [ADDR_W-1:0] CMD_PTR_ADDR = 17'h20,
    parameter logic [ADDR_W-1:0] STATUS_ADDR  = 17'h21
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              active,
    input  logic [2:0]        iop_func,
    input  logic [10:0]       iop_device,
    output logic [ADDR_W-1:0] memory_address,
    input  logic [DATA_W-1:0] memory_data_in,
    output logic [DATA_W-1:0] memory_data_out,
    output logic [3:0]        wr_enables,
    output logic [1:0]        iop_cc,
    output logic [BYTE_W-1:0] punch_data,
    output logic              punch_valid,
    input  logic              punch_ready,
    output logic              done
);

    iop_state_e        r_state;
    iop_state_e        w_state_next;
    stat_kind_e        r_stat;
    logic [15:0]       r_dw;
    logic [7:0]        r_order;
    logic [BA_W-1:0]   r_ba;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_sent;
    logic [BYTE_W-1:0] r_punch_data;
    logic              r_punch_valid;
    logic              r_done;
    logic [1:0]        r_cc;

    logic              w_dev_match;
    logic              w_handshake;
    logic [BYTE_W-1:0] w_byte;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [3:0]        w_wen;
    logic [1:0]        w_cc;
    wire               w_unused_iop = ^iop_device[10:8];

    assign w_dev_match = (iop_device[7:0] == DEVICE_ADDR);
    assign w_handshake = r_punch_valid && punch_ready;

    iop_byte_select u_byte_select (
        .i_word (memory_data_in),
        .i_lane (r_ba[1:0]),
        .o_byte (w_byte)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and memory-bus drive
    always_comb begin
        w_state_next = r_state;
        w_addr       = '0;
        w_wdata      = '0;
        w_wen        = 4'h0;
        if (!active) begin
            w_state_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_dev_match) begin
                        w_state_next = (iop_func == FNC_SIO) ? PTR : STATUS;
                    end
                end
                PTR: begin
                    w_addr       = CMD_PTR_ADDR;
                    w_state_next = CMD0;
                end
                CMD0: begin
                    w_addr       = {r_dw, 1'b0};
                    w_state_next = CMD1;
                end
                CMD1: begin
                    w_addr = {r_dw, 1'b1};
                    if (r_order != CMD_ORDER_WRITE || memory_data_in[15:0] == '0) begin
                        w_state_next = STATUS;
                    end else begin
                        w_state_next = FETCH;
                    end
                end
                FETCH: begin
                    w_addr       = r_ba[BA_W-1:2];
                    w_state_next = EMIT;
                end
                EMIT: begin
                    if (w_handshake) begin
                        w_state_next = (r_count == CNT_W'(1)) ? STATUS : FETCH;
                    end
                end
                STATUS: begin
                    w_addr = STATUS_ADDR;
                    w_wen  = 4'hF;
                    unique case (r_stat)
                        STAT_NORMAL: w_wdata = status_normal(r_sent);
                        STAT_BAD:    w_wdata = STATUS_BAD_ORDER;
                        default:     w_wdata = STATUS_TIO;
                    endcase
                    w_state_next = HOLD;
                end
                HOLD: begin
                    w_state_next = HOLD;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // Transfer bookkeeping and registered punch/handshake outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stat        <= STAT_NORMAL;
            r_dw          <= '0;
            r_order       <= '0;
            r_ba          <= '0;
            r_count       <= '0;
            r_sent        <= '0;
            r_punch_data  <= '0;
            r_punch_valid <= 1'b0;
            r_done        <= 1'b0;
            r_cc          <= 2'b00;
        end else if (!active) begin
            r_punch_valid <= 1'b0;
            r_done        <= 1'b0;
            r_count       <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_dev_match) begin
                        r_sent <= '0;
                        r_cc   <= 2'b00;
                        r_stat <= (iop_func == FNC_SIO) ? STAT_NORMAL : STAT_TIO;
                    end
                end
                PTR: begin
                    r_dw <= memory_data_in[15:0];
                end
                CMD0: begin
                    r_order <= memory_data_in[31:24];
                    r_ba    <= memory_data_in[BA_W-1:0];
                end
                CMD1: begin
                    r_count <= memory_data_in[15:0];
                    if (r_order != CMD_ORDER_WRITE) begin
                        r_stat <= STAT_BAD;
                        r_cc   <= 2'b01;
                    end
                end
                FETCH: begin
                    r_punch_data  <= w_byte;
                    r_punch_valid <= 1'b1;
                end
                EMIT: begin
                    if (w_handshake) begin
                        r_punch_valid <= 1'b0;
                        r_ba          <= r_ba + BA_W'(1);
                        r_count       <= r_count - CNT_W'(1);
                        r_sent        <= r_sent + CNT_W'(1);
                    end
                end
                STATUS: begin
                    r_done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign w_cc = (r_state == IDLE && !w_dev_match) ? 2'b11 : r_cc;

    // Shared bus: release memory and condition-code lines when not selected
    assign memory_address  = active ? w_addr  : 'z;
    assign memory_data_out = active ? w_wdata : 'z;
    assign wr_enables      = active ? w_wen   : 'z;
    assign iop_cc          = active ? w_cc    : 'z;

    assign punch_data  = r_punch_data;
    assign punch_valid = r_punch_valid;
    assign done        = r_done;

endmodule

// File: tb/tb_papertape_punch_iop.sv
// Scoreboard bench for papertape_punch_iop: expected punch bytes and status writes are queued.
module tb_papertape_punch_iop;

    logic        clock = 1'b0;
    logic        reset;
    logic        active;
    logic [2:0]  iop_func;
    logic [10:0] iop_device;
    logic [31:0] memory_data_in;
    logic        punch_ready;
    wire  [16:0] memory_address;
    wire  [31:0] memory_data_out;
    wire  [3:0]  wr_enables;
    wire  [1:0]  iop_cc;
    wire  [7:0]  punch_data;
    wire         punch_valid;
    wire         done;

    logic [31:0] mem [0:4095];
    logic [7:0]  exp_bytes [$];
    logic [48:0] exp_wr [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_bytes  = 0;

    always #5 clock = ~clock;

    papertape_punch_iop dut (
        .clock           (clock),
        .reset           (reset),
        .active          (active),
        .iop_func        (iop_func),
        .iop_device      (iop_device),
        .memory_address  (memory_address),
        .memory_data_in  (memory_data_in),
        .memory_data_out (memory_data_out),
        .wr_enables      (wr_enables),
        .iop_cc          (iop_cc),
        .punch_data      (punch_data),
        .punch_valid     (punch_valid),
        .punch_ready     (punch_ready),
        .done            (done)
    );

    always_comb memory_data_in = mem[memory_address[11:0]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every punch handshake and every memory write is matched against the queues
    always @(negedge clock) begin
        logic [7:0]  e_b;
        logic [48:0] e_w;
        if (!reset && punch_valid && punch_ready) begin
            n_bytes++;
            if (exp_bytes.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_byte: got %0h expected none", punch_data);
            end else begin
                e_b = exp_bytes.pop_front();
                check("punch_byte", 64'(punch_data), 64'(e_b));
            end
        end
        if (!reset && active && wr_enables !== 4'h0) begin
            if (exp_wr.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         memory_address, memory_data_out);
            end else begin
                e_w = exp_wr.pop_front();
                check("status_write", 64'({memory_address, memory_data_out}), 64'(e_w));
                check("status_wen", 64'(wr_enables), 64'(4'hF));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic setup_cmd(input logic [31:0] w0, input logic [31:0] w1);
        mem[12'h200] = w0;
        mem[12'h201] = w1;
    endtask

    task automatic start_op(input logic [2:0] fn);
        iop_func   = fn;
        iop_device = {3'd0, 8'h05};
        active     = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (done !== 1'b1 && k < 300) begin
            tick(1);
            k++;
        end
        check(name, 64'(done), 64'(1'b1));
    endtask

    task automatic wait_bytes(input int target);
        int k = 0;
        while (n_bytes < target && k < 200) begin
            tick(1);
            k++;
        end
        check("byte_wait", 64'(n_bytes >= target), 64'(1'b1));
    endtask

    task automatic wait_valid();
        int k = 0;
        while (punch_valid !== 1'b1 && k < 200) begin
            tick(1);
            k++;
        end
        check("valid_wait", 64'(punch_valid), 64'(1'b1));
    endtask

    task automatic end_op();
        active = 1'b0;
        tick(2);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[12'h020] = 32'h0000_0100;
        mem[12'h800] = 32'h4142_4344;
        mem[12'h801] = 32'h4546_4748;
        reset       = 1'b1;
        active      = 1'b0;
        iop_func    = 3'd0;
        iop_device  = {3'd0, 8'h05};
        punch_ready = 1'b1;
        tick(3);
        check("rst_valid", 64'(punch_valid), 64'(1'b0));
        check("rst_done", 64'(done), 64'(1'b0));
        check("rst_data", 64'(punch_data), 64'(8'h00));
        reset = 1'b0;
        tick(1);

        // Basic three-byte write from byte address 0x2000
        setup_cmd(32'h0100_2000, 32'h0000_0003);
        exp_bytes.push_back(8'h41);
        exp_bytes.push_back(8'h42);
        exp_bytes.push_back(8'h43);
        exp_wr.push_back({17'h21, 32'h0100_0003});
        start_op(3'd0);
        wait_done("a_done");
        check("a_cc", 64'(iop_cc), 64'(2'b00));
        end_op();
        check("a_done_clr", 64'(done), 64'(1'b0));

        // Word-boundary crossing from lane 3
        setup_cmd(32'h0100_2003, 32'h0000_0002);
        exp_bytes.push_back(8'h44);
        exp_bytes.push_back(8'h45);
        exp_wr.push_back({17'h21, 32'h0100_0002});
        start_op(3'd0);
        wait_done("b_done");
        check("b_cc", 64'(iop_cc), 64'(2'b00));
        end_op();

        // Punch stall for 10 cycles on the second byte
        setup_cmd(32'h0100_2000, 32'h0000_0003);
        exp_bytes.push_back(8'h41);
        exp_bytes.push_back(8'h42);
        exp_bytes.push_back(8'h43);
        exp_wr.push_back({17'h21, 32'h0100_0003});
        start_op(3'd0);
        wait_bytes(n_bytes + 1);
        punch_ready = 1'b0;
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", 64'(punch_valid), 64'(1'b1));
            check("stall_data", 64'(punch_data), 64'(8'h42));
            tick(1);
        end
        punch_ready = 1'b1;
        wait_done("c_done");
        end_op();

        // Bad order: no bytes, bad-order status, cc = 01
        setup_cmd(32'h0200_2000, 32'h0000_0003);
        exp_wr.push_back({17'h21, 32'hFF00_0000});
        start_op(3'd0);
        wait_done("d_done");
        check("d_cc", 64'(iop_cc), 64'(2'b01));
        end_op();

        // TIO
        exp_wr.push_back({17'h21, 32'h0000_0000});
        start_op(3'd1);
        wait_done("e_done");
        check("e_cc", 64'(iop_cc), 64'(2'b00));
        end_op();

        // Abort after the first byte, then a fresh two-byte SIO
        setup_cmd(32'h0100_2000, 32'h0000_0003);
        exp_bytes.push_back(8'h41);
        start_op(3'd0);
        wait_bytes(n_bytes + 1);
        active = 1'b0;
        tick(3);
        check("abort_valid", 64'(punch_valid), 64'(1'b0));
        check("abort_done", 64'(done), 64'(1'b0));
        setup_cmd(32'h0100_2000, 32'h0000_0002);
        exp_bytes.push_back(8'h41);
        exp_bytes.push_back(8'h42);
        exp_wr.push_back({17'h21, 32'h0100_0002});
        start_op(3'd0);
        wait_done("f_done");
        end_op();

        // Synchronous reset while a byte is pending
        setup_cmd(32'h0100_2000, 32'h0000_0003);
        punch_ready = 1'b0;
        start_op(3'd0);
        wait_valid();
        reset = 1'b1;
        tick(1);
        check("rst_emit_valid", 64'(punch_valid), 64'(1'b0));
        check("rst_emit_done", 64'(done), 64'(1'b0));
        check("rst_emit_data", 64'(punch_data), 64'(8'h00));
        reset  = 1'b0;
        active = 1'b0;
        tick(5);
        punch_ready = 1'b1;

        // Foreign device number is ignored
        iop_func   = 3'd0;
        iop_device = {3'd0, 8'h06};
        active     = 1'b1;
        tick(1);
        check("foreign_cc", 64'(iop_cc), 64'(2'b11));
        tick(5);
        check("foreign_cc_hold", 64'(iop_cc), 64'(2'b11));
        check("foreign_valid", 64'(punch_valid), 64'(1'b0));
        check("foreign_done", 64'(done), 64'(1'b0));
        end_op();

        tick(5);
        check("bytes_left", 64'(exp_bytes.size()), 64'(0));
        check("writes_left", 64'(exp_wr.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
